washer_input_conditioner: RTL and testbench
===========================================

# washer_input_conditioner

Front-end stage that sits directly upstream of the washing machine controller and drives its `coin_in`, `double_wash` and `timer_pause` inputs. It synchronizes and debounces the raw coin-slot and push-button signals, and accumulates coin credit. It arms one wash when enough credit is present and holds the controller's request lines stable until the controller reports `wash_done`. Debounce time is scaled by the same `clk_freq` code the controller uses, so the filter time in microseconds is the same at every clock rate.

## Interface
- `DEBOUNCE_US`, 2: debounce window in 1 MHz-equivalent cycles; effective window N = DEBOUNCE_US << clk_freq clocks.
- `PRICE`, 1: coins consumed by a single wash.
- `DOUBLE_PRICE`, 2: coins consumed by a double wash.
- `MAX_CREDIT`, 7: credit saturation value; credit register is 3 bits.
- `CNT_W`, 8: debounce counter width; must hold DEBOUNCE_US*8.
- `clk`  in  1  system clock, 1/2/4/8 MHz per `clk_freq`.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_freq`  in  2  00=1, 01=2, 10=4, 11=8 MHz; static outside reset.
- `coin_raw`  in  1  coin-slot sensor, async, bouncy, high while coin passes.
- `double_raw`  in  1  double-wash button, async, bouncy, active-high.
- `pause_raw`  in  1  pause button, async, bouncy, active-high.
- `wash_done`  in  1  from controller, synchronous to `clk`.
- `coin_in`  out  1  to controller: wash request, level.
- `double_wash`  out  1  to controller: double-wash selection, level.
- `timer_pause`  out  1  to controller: debounced pause level.
- `credit`  out  3  current unconsumed coin count.
- `double_sel`  out  1  pending double-wash selection (panel LED).

## Operation
- Each raw input passes a 2-FF synchronizer, then a debouncer. The debouncer keeps a stable bit and a counter. The counter clears whenever the synced input equals the stable bit and increments otherwise. When the counter reaches N-1 and the input still differs, the stable bit flips and the counter clears.
- Rising edge of the debounced coin (registered compare): credit += 1, saturating at MAX_CREDIT. Extra coins are dropped silently.
- FSM states: IDLE, RUNNING.
- IDLE:
  - Debounced double-button rising edge toggles `double_sel`.
  - Required = double_sel ? DOUBLE_PRICE : PRICE.
  - When credit >= required, move to RUNNING. On the same edge, credit -= required, `coin_in` goes to 1 and `double_wash` goes to `double_sel`.
- RUNNING:
  - `coin_in` and `double_wash` are held.
  - Coins still add credit.
  - Double-button edges are ignored.
  - `timer_pause` = debounced pause level. In IDLE, `timer_pause` is forced to 0.
  - On a `wash_done` 0→1 transition (previous-cycle register), move to IDLE. On the same edge `coin_in`, `double_wash` and `double_sel` go to 0.
  - A `wash_done` level already high on entry is ignored.
- Coin edge and arm on the same cycle: the arm decision uses the old credit. New credit = old - required + 1.
- Reset (any time, including mid-wash): all outputs, credit, counters and stable bits go to 0; state goes to IDLE. Any credit held at reset is lost.

## Timing
- Reset values: `coin_in`=0, `double_wash`=0, `timer_pause`=0, `credit`=0, `double_sel`=0.
- Raw edge to stable-bit change: 2 sync cycles + N cycles, for an input held clean.
- A bounce shorter than N cycles produces no change.
- Stable-bit change to credit, `double_sel` or `timer_pause` update: 1 cycle.
- Credit sufficient to `coin_in` high: 1 cycle (FSM registered).
- `wash_done` rise to `coin_in` low: 2 cycles (edge-detect register + state register).
- After `wash_done`, `coin_in` stays low for at least 1 cycle before any re-arm.
- All outputs come from registers; there is no combinational path from input to output.

## Test plan
- Reset mid-RUNNING with credit=3: assert `rst` for 1 cycle → all outputs 0 asynchronously, state IDLE. No re-arm until new coins are inserted.
- `clk_freq`=11, DEBOUNCE_US=2 (N=16): one clean `coin_raw` pulse of 20 cycles → `credit` 0→1 exactly 19 cycles after the raw rise. `coin_in` rises on the next cycle and `credit` returns to 0.
- `clk_freq`=00 (N=2): `coin_raw` toggles every cycle for 40 cycles, then settles high → exactly one credit increment.
- Double wash: press `double_raw` (`double_sel`=1), then insert 1 coin → `coin_in` stays 0 with `credit`=1. Insert a 2nd coin → `coin_in`=1, `double_wash`=1, `credit`=0.
- In RUNNING, hold `pause_raw` 40 cycles → `timer_pause` high for about 40 cycles, shifted by 2+N+1. Pulse `wash_done` → `coin_in`=0 two cycles later and `timer_pause` forced to 0.
- Insert 9 coins in IDLE with `double_sel`=1 and DOUBLE_PRICE raised to 8: `credit` saturates at 7 and never reaches the price, so `coin_in` never asserts.

Source files
------------

// File: rtl/washer_input_conditioner_if.sv
// Signal bundle between the washer front-end conditioner and its user.
// Carries raw panel inputs, the controller handshake and the conditioned outputs.
interface washer_input_conditioner_if;
   logic [1:0] clk_freq;
   logic       coin_raw;
   logic       double_raw;
   logic       pause_raw;
   logic       wash_done;
   logic       coin_in;
   logic       double_wash;
   logic       timer_pause;
   logic [2:0] credit;
   logic       double_sel;

   modport master (
      output clk_freq,
      output coin_raw,
      output double_raw,
      output pause_raw,
      output wash_done,
      input  coin_in,
      input  double_wash,
      input  timer_pause,
      input  credit,
      input  double_sel
   );

   modport slave (
      input  clk_freq,
      input  coin_raw,
      input  double_raw,
      input  pause_raw,
      input  wash_done,
      output coin_in,
      output double_wash,
      output timer_pause,
      output credit,
      output double_sel
   );
endinterface

// File: rtl/washer_input_conditioner.sv
// Washer front end: syncs/debounces coin, double and pause inputs, keeps credit,
// arms one wash and holds coin_in/double_wash until wash_done rises.
// Ports: clk, rst (async high), bus (slave): clk_freq, *_raw, wash_done in;
// coin_in, double_wash, timer_pause, credit, double_sel out.

module washer_debounce #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             raw,
   input  logic [CNT_W-1:0] last,
   output logic             stable
);
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic             synced;

   assign synced = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[0], raw};
      end
   end

   // stable only follows the input after it has differed for last+1 clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         stable <= 1'b0;
      end else if (synced == stable) begin
         cnt <= '0;
      end else if (cnt == last) begin
         cnt    <= '0;
         stable <= ~stable;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

module washer_input_conditioner #(
   parameter int DEBOUNCE_US  = 2,
   parameter int PRICE        = 1,
   parameter int DOUBLE_PRICE = 2,
   parameter int MAX_CREDIT   = 7,
   parameter int CNT_W        = 8
) (
   input logic                       clk,
   input logic                       rst,
   washer_input_conditioner_if.slave bus
);
   typedef enum logic {
      IDLE,
      RUNNING
   } state_t;

   localparam logic [3:0] PRICE4  = 4'(PRICE);
   localparam logic [3:0] DPRICE4 = 4'(DOUBLE_PRICE);
   localparam logic [3:0] MAX4    = 4'(MAX_CREDIT);
   localparam logic [2:0] MAX3    = 3'(MAX_CREDIT);

   state_t     state;
   state_t     state_d;
   logic [2:0] credit_r;
   logic [2:0] credit_d;
   logic       coin_in_r;
   logic       coin_in_d;
   logic       dw_r;
   logic       dw_d;
   logic       ds_r;
   logic       ds_d;
   logic       tp_r;
   logic       tp_d;

   logic [CNT_W-1:0] last;
   logic             coin_stb;
   logic             dbl_stb;
   logic             pause_stb;
   logic             coin_q;
   logic             dbl_q;
   logic             done_q;
   logic             done_rise;
   logic             coin_edge;
   logic             dbl_edge;
   logic             arm;
   logic [3:0]       req;
   logic [3:0]       sum;

   // window scales with clock rate so the filter time stays constant in us
   assign last = (CNT_W'(DEBOUNCE_US) << bus.clk_freq) - CNT_W'(1);

   washer_debounce #(.CNT_W(CNT_W)) u_coin (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.coin_raw),
      .last   (last),
      .stable (coin_stb)
   );

   washer_debounce #(.CNT_W(CNT_W)) u_dbl (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.double_raw),
      .last   (last),
      .stable (dbl_stb)
   );

   washer_debounce #(.CNT_W(CNT_W)) u_pause (
      .clk    (clk),
      .rst    (rst),
      .raw    (bus.pause_raw),
      .last   (last),
      .stable (pause_stb)
   );

   // done_rise is registered so a level already high never looks like an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coin_q    <= 1'b0;
         dbl_q     <= 1'b0;
         done_q    <= 1'b0;
         done_rise <= 1'b0;
      end else begin
         coin_q    <= coin_stb;
         dbl_q     <= dbl_stb;
         done_q    <= bus.wash_done;
         done_rise <= bus.wash_done & ~done_q;
      end
   end

   assign coin_edge = coin_stb & ~coin_q;
   assign dbl_edge  = dbl_stb & ~dbl_q;
   assign req       = ds_r ? DPRICE4 : PRICE4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         credit_r  <= '0;
         coin_in_r <= 1'b0;
         dw_r      <= 1'b0;
         ds_r      <= 1'b0;
         tp_r      <= 1'b0;
      end else begin
         state     <= state_d;
         credit_r  <= credit_d;
         coin_in_r <= coin_in_d;
         dw_r      <= dw_d;
         ds_r      <= ds_d;
         tp_r      <= tp_d;
      end
   end

   always_comb begin
      state_d   = state;
      coin_in_d = coin_in_r;
      dw_d      = dw_r;
      ds_d      = ds_r;
      arm       = 1'b0;
      unique case (state)
         IDLE: begin
            if ({1'b0, credit_r} >= req) begin
               arm       = 1'b1;
               state_d   = RUNNING;
               coin_in_d = 1'b1;
               dw_d      = ds_r;
            end else if (dbl_edge) begin
               ds_d = ~ds_r;
            end
         end
         RUNNING: begin
            if (done_rise) begin
               state_d   = IDLE;
               coin_in_d = 1'b0;
               dw_d      = 1'b0;
               ds_d      = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // arm uses the old credit; a coin on the same edge still counts
      sum = {1'b0, credit_r} + {3'b000, coin_edge};
      if (arm) begin
         sum = sum - req;
      end
      credit_d = (sum > MAX4) ? MAX3 : sum[2:0];
      tp_d     = (state_d == RUNNING) & pause_stb;
   end

   assign bus.coin_in     = coin_in_r;
   assign bus.double_wash = dw_r;
   assign bus.timer_pause = tp_r;
   assign bus.credit      = credit_r;
   assign bus.double_sel  = ds_r;
endmodule

// File: tb/tb_washer_input_conditioner.sv
// Bench for washer_input_conditioner: random and directed panel stimulus
// against a window-based behavioural model, plus literal timing pins.
module tb_washer_input_conditioner;
   localparam int DBUS = 2;
   localparam int P    = 1;
   localparam int DP   = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   washer_input_conditioner_if bus1 ();
   washer_input_conditioner_if bus2 ();

   washer_input_conditioner #(
      .DEBOUNCE_US  (DBUS),
      .PRICE        (P),
      .DOUBLE_PRICE (DP),
      .MAX_CREDIT   (7),
      .CNT_W        (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   washer_input_conditioner #(
      .DEBOUNCE_US  (DBUS),
      .PRICE        (P),
      .DOUBLE_PRICE (8),
      .MAX_CREDIT   (7),
      .CNT_W        (8)
   ) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // model: raw sample history per channel (coin, double, pause, wash_done)
   bit hist[4][24];
   bit st[3];
   bit stp[3];
   bit m_run;
   bit m_dw;
   bit m_ds;
   bit m_tp;
   int m_cr;

   task automatic mreset();
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 24; i++) hist[c][i] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         st[c]  = 1'b0;
         stp[c] = 1'b0;
      end
      m_run = 0;
      m_dw  = 0;
      m_ds  = 0;
      m_tp  = 0;
      m_cr  = 0;
   endtask

   // true when every synced sample in the last n clocks differs from s
   function automatic bit held(input int ch, input int n, input bit s);
      for (int i = 2; i <= n + 1; i++)
         if (hist[ch][i] == s) return 1'b0;
      return 1'b1;
   endfunction

   task automatic mstep();
      int n;
      int req;
      bit rc;
      bit rd;
      bit rw;
      bit pz;
      bit arm;
      bit [3:0] raws;
      n    = DBUS << int'(bus1.clk_freq);
      raws = {bus1.wash_done, bus1.pause_raw, bus1.double_raw, bus1.coin_raw};
      for (int c = 0; c < 4; c++) begin
         for (int i = 23; i > 0; i--) hist[c][i] = hist[c][i-1];
         hist[c][0] = raws[c];
      end
      rc = st[0] & ~stp[0];
      rd = st[1] & ~stp[1];
      pz = st[2];
      rw = hist[3][1] & ~hist[3][2];
      for (int c = 0; c < 3; c++) begin
         stp[c] = st[c];
         if (held(c, n, st[c])) st[c] = ~st[c];
      end
      req = m_ds ? DP : P;
      arm = !m_run && (m_cr >= req);
      if (!m_run) begin
         if (arm) begin
            m_run = 1;
            m_dw  = m_ds;
         end else if (rd) begin
            m_ds = ~m_ds;
         end
      end else if (rw) begin
         m_run = 0;
         m_dw  = 0;
         m_ds  = 0;
      end
      m_cr = m_cr + int'(rc) - (arm ? req : 0);
      if (m_cr > 7) m_cr = 7;
      m_tp = m_run & pz;
   endtask

   initial begin
      mreset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) mreset();
         else mstep();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if (bus1.coin_in !== m_run || bus1.double_wash !== m_dw ||
                bus1.timer_pause !== m_tp || int'(bus1.credit) != m_cr ||
                bus1.double_sel !== m_ds) begin
               errors++;
               $display("FAIL model t=%0t actual/required coin_in %b/%b dw %b/%b tp %b/%b credit %0d/%0d ds %b/%b",
                        $time, bus1.coin_in, m_run, bus1.double_wash, m_dw,
                        bus1.timer_pause, m_tp, bus1.credit, m_cr,
                        bus1.double_sel, m_ds);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input logic [1:0] f);
      rst = 1'b1;
      #1;
      chk("rst_coin_in", int'(bus1.coin_in), 0);
      chk("rst_outs", int'({bus1.double_wash, bus1.timer_pause,
                            bus1.credit, bus1.double_sel}), 0);
      bus1.clk_freq   = f;
      bus1.coin_raw   = 0;
      bus1.double_raw = 0;
      bus1.pause_raw  = 0;
      bus1.wash_done  = 0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic coin1();
      bus1.coin_raw = 1;
      tick(6);
      bus1.coin_raw = 0;
      tick(6);
   endtask

   int k;
   int cnt;
   int hold[4];
   bit seen;

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bus1.clk_freq = 0;
      bus1.coin_raw = 0;
      bus1.double_raw = 0;
      bus1.pause_raw = 0;
      bus1.wash_done = 0;
      bus2.clk_freq = 0;
      bus2.coin_raw = 0;
      bus2.double_raw = 0;
      bus2.pause_raw = 0;
      bus2.wash_done = 0;
      tick(1);

      // coin latency at 8 MHz, N=16
      do_reset(2'b11);
      bus1.coin_raw = 1;
      k = 61;
      for (int i = 1; i <= 60; i++) begin
         tick(1);
         if (bus1.credit == 3'd1) begin
            k = i;
            break;
         end
      end
      chk("coin_latency", k, 19);
      tick(1);
      chk("arm_coin_in", int'(bus1.coin_in), 1);
      chk("arm_credit", int'(bus1.credit), 0);
      bus1.coin_raw = 0;
      tick(30);

      // bounce rejection with double selection pending, N=2
      do_reset(2'b00);
      bus1.double_raw = 1;
      tick(6);
      bus1.double_raw = 0;
      tick(6);
      chk("dbl_sel", int'(bus1.double_sel), 1);
      for (int i = 0; i < 40; i++) begin
         bus1.coin_raw = ~i[0];
         tick(1);
      end
      bus1.coin_raw = 1;
      tick(8);
      chk("bounce_credit", int'(bus1.credit), 1);
      chk("bounce_coin_in", int'(bus1.coin_in), 0);
      bus1.coin_raw = 0;
      tick(6);
      bus1.coin_raw = 1;
      tick(8);
      chk("dbl_coin_in", int'(bus1.coin_in), 1);
      chk("dbl_wash", int'(bus1.double_wash), 1);
      chk("dbl_credit", int'(bus1.credit), 0);
      bus1.coin_raw = 0;
      tick(6);

      // pause passthrough in RUNNING, then wash_done
      cnt = 0;
      bus1.pause_raw = 1;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (bus1.timer_pause) cnt++;
         if (i == 39) bus1.pause_raw = 0;
      end
      chk("pause_len", cnt, 40);
      bus1.pause_raw = 1;
      tick(8);
      chk("pause_on", int'(bus1.timer_pause), 1);
      bus1.wash_done = 1;
      tick(1);
      chk("done_c1", int'(bus1.coin_in), 1);
      tick(1);
      chk("done_c2", int'(bus1.coin_in), 0);
      chk("done_tp", int'(bus1.timer_pause), 0);
      chk("done_ds", int'(bus1.double_sel), 0);
      bus1.wash_done = 0;
      bus1.pause_raw = 0;
      tick(6);

      // reset mid-wash with credit 3
      do_reset(2'b00);
      repeat (4) coin1();
      chk("mid_coin_in", int'(bus1.coin_in), 1);
      chk("mid_credit", int'(bus1.credit), 3);
      rst = 1'b1;
      #1;
      chk("async_coin_in", int'(bus1.coin_in), 0);
      chk("async_credit", int'(bus1.credit), 0);
      tick(1);
      rst = 1'b0;
      tick(20);
      chk("post_rst_coin_in", int'(bus1.coin_in), 0);

      // random stimulus at every clock rate
      for (int f = 0; f < 4; f++) begin
         do_reset(2'(f));
         for (int c = 0; c < 3; c++) hold[c] = 1;
         for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 3; c++) begin
               hold[c]--;
               if (hold[c] <= 0) begin
                  hold[c] = $urandom_range(1, 3 * (DBUS << f));
                  case (c)
                     0: bus1.coin_raw = ~bus1.coin_raw;
                     1: bus1.double_raw = ~bus1.double_raw;
                     default: bus1.pause_raw = ~bus1.pause_raw;
                  endcase
               end
            end
            if ($urandom_range(0, 15) == 0) bus1.wash_done = ~bus1.wash_done;
            tick(1);
         end
      end

      // saturation on the second instance (double price 8)
      do_reset(2'b00);
      bus2.double_raw = 1;
      tick(6);
      bus2.double_raw = 0;
      tick(6);
      chk("sat_dbl_sel", int'(bus2.double_sel), 1);
      seen = 0;
      for (int j = 0; j < 9; j++) begin
         bus2.coin_raw = 1;
         for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus2.coin_in) seen = 1;
         end
         bus2.coin_raw = 0;
         for (int i = 0; i < 6; i++) begin
            tick(1);
            if (bus2.coin_in) seen = 1;
         end
      end
      chk("sat_credit", int'(bus2.credit), 7);
      chk("sat_no_arm", int'(seen), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
